tft_timing_gen: RTL

Parametrised TFT panel timing generator and pixel output stage for the OV5640 → SDRAM → TFT display path. It sits between the SDRAM read FIFO and the panel pins. It generates hsync, vsync, data-enable and a configurable-lead FIFO read request from programmable porch and sync widths, plus per-pixel coordinates. It adds frame-boundary start/stop control, configurable sync polarity, and underflow detection with a fill colour, so one block serves the 480x272 panel and larger panels.

---
 rtl/tft_timing_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tft_timing_gen.sv
// TFT panel timing generator: programmable porches/sync widths, frame-boundary
// start/stop control, FIFO read request with configurable lead, underflow fill.
module tft_timing_gen #(
   parameter int               H_SYNC   = 41,
   parameter int               H_BACK   = 2,
   parameter int               H_VALID  = 480,
   parameter int               H_FRONT  = 2,
   parameter int               V_SYNC   = 10,
   parameter int               V_BACK   = 2,
   parameter int               V_VALID  = 272,
   parameter int               V_FRONT  = 2,
   parameter int               DATA_W   = 16,
   parameter int               REQ_LEAD = 1,
   parameter logic             HS_POL   = 1'b0,
   parameter logic             VS_POL   = 1'b0,
   parameter logic [DATA_W-1:0] FILL    = {DATA_W{1'b0}},
   parameter int               CNT_W    = 11
) (
   input  logic              i_clk_pix,
   input  logic              i_sysrst_n,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_data_in,
   input  logic              i_data_vld,
   input  logic              i_clr_err,
   output logic              o_read_data_req,
   output logic [DATA_W-1:0] o_rgb_data_tft,
   output logic              o_tft_hsync,
   output logic              o_tft_vsync,
   output logic              o_tft_de,
   output logic              o_tft_clk,
   output logic              o_tft_bl,
   output logic [CNT_W-1:0]  o_pix_x,
   output logic [CNT_W-1:0]  o_pix_y,
   output logic              o_frame_start,
   output logic              o_underflow
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HA0     = H_SYNC + H_BACK;
   localparam int VA0     = V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HA_BEG  = CNT_W'(HA0);
   localparam logic [CNT_W-1:0] HA_END  = CNT_W'(HA0 + H_VALID);
   localparam logic [CNT_W-1:0] VA_BEG  = CNT_W'(VA0);
   localparam logic [CNT_W-1:0] VA_END  = CNT_W'(VA0 + V_VALID);
   localparam logic [CNT_W-1:0] REQ_BEG = CNT_W'(HA0 - REQ_LEAD);
   localparam logic [CNT_W-1:0] REQ_END = CNT_W'(HA0 + H_VALID - REQ_LEAD);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_h_q, cnt_h_d;
   logic [CNT_W-1:0]  cnt_v_q, cnt_v_d;

   logic              de_q, de_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic [DATA_W-1:0] rgb_q, rgb_d;
   logic [CNT_W-1:0]  pix_x_q, pix_x_d;
   logic [CNT_W-1:0]  pix_y_q, pix_y_d;
   logic              frame_start_q, frame_start_d;
   logic              bl_q, bl_d;
   logic              underflow_q, underflow_d;

   logic counting;
   logic frame_end;
   logic h_act;
   logic v_act;
   logic act;
   logic req;

   // Window decode from the current counter state
   always_comb begin
      counting  = (state_q != ST_IDLE);
      frame_end = counting && (cnt_h_q == H_LAST) && (cnt_v_q == V_LAST);
      h_act     = (cnt_h_q >= HA_BEG) && (cnt_h_q < HA_END);
      v_act     = (cnt_v_q >= VA_BEG) && (cnt_v_q < VA_END);
      act       = counting && h_act && v_act;
      req       = counting && v_act && (cnt_h_q >= REQ_BEG) && (cnt_h_q < REQ_END);
   end

   // Run/stop FSM: a stop request only takes effect at the frame boundary
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_en) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_en) begin
               state_d = ST_RUN;
            end else if (frame_end) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (i_en) begin
               state_d = ST_RUN;
            end else if (frame_end) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel/line counters, held at zero while idle
   always_comb begin
      cnt_h_d = cnt_h_q;
      cnt_v_d = cnt_v_q;
      if (!counting) begin
         cnt_h_d = {CNT_W{1'b0}};
         cnt_v_d = {CNT_W{1'b0}};
      end else if (cnt_h_q == H_LAST) begin
         cnt_h_d = {CNT_W{1'b0}};
         if (cnt_v_q == V_LAST) begin
            cnt_v_d = {CNT_W{1'b0}};
         end else begin
            cnt_v_d = cnt_v_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_h_d = cnt_h_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Panel-side output values, all derived from the same counter state
   always_comb begin
      de_d          = act;
      hsync_d       = (counting && (cnt_h_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = (counting && (cnt_v_q < VS_END)) ? VS_POL : ~VS_POL;
      frame_start_d = counting && (cnt_h_q == {CNT_W{1'b0}}) && (cnt_v_q == {CNT_W{1'b0}});
      bl_d          = counting;
      if (act) begin
         rgb_d   = i_data_vld ? i_data_in : FILL;
         pix_x_d = cnt_h_q - HA_BEG;
         pix_y_d = cnt_v_q - VA_BEG;
      end else begin
         rgb_d   = {DATA_W{1'b0}};
         pix_x_d = {CNT_W{1'b0}};
         pix_y_d = {CNT_W{1'b0}};
      end
      // A new underflow wins over a coincident clear so no event is lost
      if (act && !i_data_vld) begin
         underflow_d = 1'b1;
      end else if (i_clr_err) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // State, counters and output registers with synchronous reset
   always_ff @(posedge i_clk_pix) begin
      if (!i_sysrst_n) begin
         state_q       <= ST_IDLE;
         cnt_h_q       <= {CNT_W{1'b0}};
         cnt_v_q       <= {CNT_W{1'b0}};
         de_q          <= 1'b0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         rgb_q         <= {DATA_W{1'b0}};
         pix_x_q       <= {CNT_W{1'b0}};
         pix_y_q       <= {CNT_W{1'b0}};
         frame_start_q <= 1'b0;
         bl_q          <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_h_q       <= cnt_h_d;
         cnt_v_q       <= cnt_v_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= frame_start_d;
         bl_q          <= bl_d;
         underflow_q   <= underflow_d;
      end
   end

   assign o_read_data_req = req;
   assign o_rgb_data_tft  = rgb_q;
   assign o_tft_hsync     = hsync_q;
   assign o_tft_vsync     = vsync_q;
   assign o_tft_de        = de_q;
   assign o_tft_clk       = i_clk_pix;
   assign o_tft_bl        = bl_q;
   assign o_pix_x         = pix_x_q;
   assign o_pix_y         = pix_y_q;
   assign o_frame_start   = frame_start_q;
   assign o_underflow     = underflow_q;

endmodule
